// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl
// Sequential shift-add multiplier controller. Computes the unsigned product
// of two W-bit operands by reusing one external W-bit adder (adder_8) for W
// clock cycles, one partial-product step per cycle.
//
// Ports:
//   clk      in   rising-edge system clock
//   rst_n    in   asynchronous active-low reset
//   start    in   operation request, sampled only in IDLE
//   a_in     in   W-bit multiplicand, captured on the accept edge
//   b_in     in   W-bit multiplier, captured on the accept edge
//   busy     out  high while iterating (RUN)
//   done     out  one-cycle completion pulse (DONE)
//   product  out  2W-bit registered product, held until the next completion
//   add_a    out  adder operand a (accumulator high half)
//   add_b    out  adder operand b (multiplicand or zero)
//   add_ci   out  adder carry-in, tied to 0
//   add_s    in   adder sum (combinational from add_a/add_b/add_ci)
//   add_co   in   adder carry-out
module seq_mult_ctrl #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    output logic           add_ci,
    input  logic [W-1:0]   add_s,
    input  logic           add_co
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  mcand;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [CW-1:0] cnt;

    // The low accumulator half doubles as the multiplier shift register, so
    // its LSB is the multiplier bit for the current step.
    assign add_a  = acc_hi;
    assign add_b  = acc_lo[0] ? mcand : '0;
    assign add_ci = 1'b0;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_in;
                        acc_lo <= b_in;
                        acc_hi <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // Sum (with carry as bit W) shifts right by one across
                    // both accumulator halves; the consumed multiplier bit
                    // falls off the bottom of acc_lo.
                    acc_hi <= {add_co, add_s[W-1:1]};
                    acc_lo <= {add_s[0], acc_lo[W-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        product <= {add_co, add_s, acc_lo[W-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_ci;
    logic [7:0]  add_s;
    logic        add_co;

    int errors = 0;
    int checks = 0;

    seq_mult_ctrl #(.W(8), .CW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .product (product),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_ci  (add_ci),
        .add_s   (add_s),
        .add_co  (add_co)
    );

    // Behavioural model of the external adder_8.
    always_comb begin
        {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_ci};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags: busy=%b done=%b required busy=0 done=0", busy, done);
            end
            checks++;
            if (product !== 16'h0000) begin
                errors++;
                $display("FAIL reset_product: got %h required 0000", product);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || add_ci !== 1'b0 || product !== 16'h0000) begin
                errors++;
                $display("FAIL idle_after_reset: busy=%b done=%b ci=%b product=%h required 0 0 0 0000",
                         busy, done, add_ci, product);
            end
        end
    endtask

    task automatic test_basic;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'hF6;
        b = 8'h0A;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy[%0d]: busy=%b done=%b required 1 0", k, busy, done);
            end
            checks++;
            if (add_b !== (b[k] ? a : 8'h00) || add_ci !== 1'b0) begin
                errors++;
                $display("FAIL basic_add_b[%0d]: add_b=%h ci=%b required %h 0", k, add_b, add_ci,
                         b[k] ? a : 8'h00);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== 16'h099C) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b product=%h required 1 0 099c", done, busy, product);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h099C) begin
                errors++;
                $display("FAIL basic_hold: done=%b busy=%b product=%h required 0 0 099c", done, busy, product);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  av [3];
        logic [7:0]  bv [3];
        logic [15:0] pv [3];
        int n;
        int cyc;
        int last;
        av[0] = 8'hFF; bv[0] = 8'hFF; pv[0] = 16'hFE01;
        av[1] = 8'h00; bv[1] = 8'h55; pv[1] = 16'h0000;
        av[2] = 8'h01; bv[2] = 8'h80; pv[2] = 16'h0080;
        n = 0;
        cyc = 0;
        last = 0;
        a_in  = av[0];
        b_in  = bv[0];
        start = 1'b1;
        while (n < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                checks++;
                if (product !== pv[n]) begin
                    errors++;
                    $display("FAIL b2b_product[%0d]: got %h required %h", n, product, pv[n]);
                end
                checks++;
                if ((n == 0 && cyc != 9) || (n > 0 && cyc - last != 10)) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: done at cycle %0d (prev %0d) required %0d",
                             n, cyc, last, (n == 0) ? 9 : last + 10);
                end
                last = cyc;
                n++;
                if (n < 3) begin
                    a_in = av[n];
                    b_in = bv[n];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL b2b_timeout: saw %0d done pulses required 3", n);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_quiet[%0d]: done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int ndone;
        int at;
        ndone = 0;
        at = -1;
        a_in  = 8'h03;
        b_in  = 8'h05;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3) begin
                a_in  = 8'h7F;
                b_in  = 8'h7F;
                start = 1'b1;
            end
            if (i == 4) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                at = i;
                checks++;
                if (product !== 16'h000F) begin
                    errors++;
                    $display("FAIL ignore_product: got %h required 000f", product);
                end
            end
            tick();
        end
        checks++;
        if (ndone != 1 || at != 9) begin
            errors++;
            $display("FAIL ignore_done_count: %0d pulses (first at %0d) required 1 at 9", ndone, at);
        end
        checks++;
        if (product !== 16'h000F) begin
            errors++;
            $display("FAIL ignore_hold: got %h required 000f", product);
        end
    endtask

    task automatic test_reset_midop;
        int wait_cyc;
        a_in  = 8'h12;
        b_in  = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_running: busy=%b required 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL midop_async_reset: busy=%b done=%b product=%h required 0 0 0000",
                     busy, done, product);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midop_in_reset: done=%b busy=%b required 0 0", done, busy);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midop_no_done: done=%b busy=%b required 0 0", done, busy);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cyc = 0;
        while (done !== 1'b1 && wait_cyc < 12) begin
            tick();
            wait_cyc++;
        end
        checks++;
        if (done !== 1'b1 || wait_cyc != 8 || product !== 16'h03A8) begin
            errors++;
            $display("FAIL midop_rerun: done=%b after %0d cycles product=%h required 1 after 8 03a8",
                     done, wait_cyc, product);
        end
        tick();
    endtask

    task automatic test_random;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] partial;
        logic [15:0] mask;
        logic [7:0]  exp_hi;
        for (int n = 0; n < 200; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            a_in  = a;
            b_in  = b;
            start = 1'b1;
            tick();
            start = 1'b0;
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            for (int k = 0; k < 8; k++) begin
                mask    = (16'd1 << k) - 16'd1;
                partial = {8'd0, a} * ({8'd0, b} & mask);
                exp_hi  = 8'(partial >> k);
                checks++;
                if (add_b !== (b[k] ? a : 8'h00)) begin
                    errors++;
                    $display("FAIL rand_add_b[%0d/%0d]: a=%h b=%h add_b=%h required %h",
                             n, k, a, b, add_b, b[k] ? a : 8'h00);
                end
                checks++;
                if (add_a !== exp_hi || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_add_a[%0d/%0d]: a=%h b=%h add_a=%h busy=%b required %h 1",
                             n, k, a, b, add_a, busy, exp_hi);
                end
                tick();
            end
            checks++;
            if (done !== 1'b1 || product !== {8'd0, a} * {8'd0, b}) begin
                errors++;
                $display("FAIL rand_product[%0d]: a=%h b=%h done=%b product=%h required 1 %h",
                         n, a, b, done, product, {8'd0, a} * {8'd0, b});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_busy();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
